micro_sequencer: RTL

//  Microprogram sequencer for the ARC-style datapath control unit; directly downstream of the branch logic.

---
 rtl/micro_sequencer_pkg.sv | 36 +++
 rtl/micro_sequencer_if.sv | 42 ++++
 rtl/micro_sequencer_next_addr.sv | 34 +++
 rtl/micro_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: Tipo and FSM encodings,
// decode-address field positions and the default widths and trap address.
package micro_sequencer_pkg;

    localparam int ADDR_W      = 11;
    localparam int IR_W        = 32;
    localparam int TIPO_W      = 2;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [10:0] TRAP_ADDR = 11'h7F0;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 30;
    localparam int OP3_HI = 24;
    localparam int OP3_LO = 19;

    typedef enum logic [1:0] {
        TIPO_NEXT   = 2'b00,
        TIPO_JUMP   = 2'b01,
        TIPO_DECODE = 2'b10,
        TIPO_RSVD   = 2'b11
    } tipo_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_WAIT   = 2'b10,
        ST_UNUSED = 2'b11
    } state_e;

    // Decode dispatch lands in the upper half of the control store, indexed by op/op3.
    function automatic logic [10:0] decode_addr(input logic [IR_W-1:0] ir);
        return {1'b1, ir[OP_HI:OP_LO], ir[OP3_HI:OP3_LO], 2'b00};
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Bus between the branch logic / memory side and the microprogram sequencer.
interface micro_sequencer_if #(
    parameter int ADDR = micro_sequencer_pkg::ADDR_W,
    parameter int IR   = micro_sequencer_pkg::IR_W,
    parameter int TIPO = micro_sequencer_pkg::TIPO_W
);

    logic [TIPO-1:0] MICRO_SEQUENCER_Tipo_InBus;
    logic [ADDR-1:0] MICRO_SEQUENCER_JumpAddr_InBus;
    logic [IR-1:0]   MICRO_SEQUENCER_IR_InBus;
    logic            MICRO_SEQUENCER_MemReq_In;
    logic            MICRO_SEQUENCER_MemAck_In;
    logic [ADDR-1:0] MICRO_SEQUENCER_MicroPC_OutBus;
    logic            MICRO_SEQUENCER_Stall_Out;
    logic            MICRO_SEQUENCER_Timeout_Out;
    logic [1:0]      MICRO_SEQUENCER_State_OutBus;

    modport master (
        output MICRO_SEQUENCER_Tipo_InBus,
        output MICRO_SEQUENCER_JumpAddr_InBus,
        output MICRO_SEQUENCER_IR_InBus,
        output MICRO_SEQUENCER_MemReq_In,
        output MICRO_SEQUENCER_MemAck_In,
        input  MICRO_SEQUENCER_MicroPC_OutBus,
        input  MICRO_SEQUENCER_Stall_Out,
        input  MICRO_SEQUENCER_Timeout_Out,
        input  MICRO_SEQUENCER_State_OutBus
    );

    modport slave (
        input  MICRO_SEQUENCER_Tipo_InBus,
        input  MICRO_SEQUENCER_JumpAddr_InBus,
        input  MICRO_SEQUENCER_IR_InBus,
        input  MICRO_SEQUENCER_MemReq_In,
        input  MICRO_SEQUENCER_MemAck_In,
        output MICRO_SEQUENCER_MicroPC_OutBus,
        output MICRO_SEQUENCER_Stall_Out,
        output MICRO_SEQUENCER_Timeout_Out,
        output MICRO_SEQUENCER_State_OutBus
    );

endinterface

// File: rtl/micro_sequencer_next_addr.sv
// Combinational next-microaddress selection: sequential, jump field, or opcode decode.
module micro_next_addr
    import micro_sequencer_pkg::*;
#(
    parameter int ADDR = ADDR_W,
    parameter int IR   = IR_W,
    parameter int TIPO = TIPO_W
) (
    input  logic [TIPO-1:0] tipo,
    input  logic [ADDR-1:0] micro_pc,
    input  logic [ADDR-1:0] jump_addr,
    input  logic [IR-1:0]   ir,
    output logic [ADDR-1:0] next_addr
);

    logic [ADDR-1:0] seq_addr;
    logic [ADDR-1:0] dec_addr;
    logic            unused_ir_bits;

    assign seq_addr       = micro_pc + ADDR'(1);
    assign dec_addr       = ADDR'(decode_addr(IR_W'(ir)));
    assign unused_ir_bits = ^ir;

    // The reserved Tipo code behaves exactly like a plain sequential step.
    always_comb begin
        next_addr = seq_addr;
        case (tipo_e'(tipo[1:0]))
            TIPO_JUMP:   next_addr = jump_addr;
            TIPO_DECODE: next_addr = dec_addr;
            default:     next_addr = seq_addr;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered microPC, memory-wait freeze and a watchdog
// that forces a trap microaddress when an access is never acknowledged.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int                            MICRO_SEQUENCER_ADDR    = ADDR_W,
    parameter int                            MICRO_SEQUENCER_IR      = IR_W,
    parameter int                            MICRO_SEQUENCER_TIPO    = TIPO_W,
    parameter int                            MICRO_SEQUENCER_TIMEOUT = TIMEOUT_DEF,
    parameter logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_TRAP  = TRAP_ADDR
) (
    input logic              MICRO_SEQUENCER_CLOCK_50,
    input logic              MICRO_SEQUENCER_ResetInHigh_In,
    micro_sequencer_if.slave bus
);

    localparam int ADDR  = MICRO_SEQUENCER_ADDR;
    localparam int CNT_W = $clog2(MICRO_SEQUENCER_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MICRO_SEQUENCER_TIMEOUT - 1);

    logic clk;
    logic rst;
    assign clk = MICRO_SEQUENCER_CLOCK_50;
    assign rst = MICRO_SEQUENCER_ResetInHigh_In;

    state_e            state_q, state_d;
    logic [ADDR-1:0]   micro_pc_q, micro_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              stall;
    logic [ADDR-1:0]   next_addr;
    logic              mem_req;
    logic              mem_ack;

    assign mem_req = bus.MICRO_SEQUENCER_MemReq_In;
    assign mem_ack = bus.MICRO_SEQUENCER_MemAck_In;

    micro_next_addr #(
        .ADDR (MICRO_SEQUENCER_ADDR),
        .IR   (MICRO_SEQUENCER_IR),
        .TIPO (MICRO_SEQUENCER_TIPO)
    ) u_next_addr (
        .tipo      (bus.MICRO_SEQUENCER_Tipo_InBus),
        .micro_pc  (micro_pc_q),
        .jump_addr (bus.MICRO_SEQUENCER_JumpAddr_InBus),
        .ir        (bus.MICRO_SEQUENCER_IR_InBus),
        .next_addr (next_addr)
    );

    // An ack arriving in the last allowed wait cycle takes priority over the trap.
    always_comb begin
        state_d    = state_q;
        micro_pc_d = micro_pc_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        stall      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_WAIT;
                end else begin
                    stall      = 1'b0;
                    micro_pc_d = next_addr;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    stall      = 1'b0;
                    micro_pc_d = next_addr;
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    micro_pc_d = MICRO_SEQUENCER_TRAP;
                    timeout_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            micro_pc_q <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            micro_pc_q <= micro_pc_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.MICRO_SEQUENCER_MicroPC_OutBus = micro_pc_q;
    assign bus.MICRO_SEQUENCER_Stall_Out      = stall;
    assign bus.MICRO_SEQUENCER_Timeout_Out    = timeout_q;
    assign bus.MICRO_SEQUENCER_State_OutBus   = state_q;

    // The watchdog counter must never reach TIMEOUT, and the timeout flag only clears on reset.
    cnt_bounded: assert property (@(posedge clk) disable iff (rst)
        cnt_q < CNT_W'(MICRO_SEQUENCER_TIMEOUT));
    timeout_sticky: assert property (@(posedge clk) disable iff (rst)
        timeout_q |=> timeout_q);

endmodule
